// File: rtl/sorter_ctrl_axil_master.sv
// AXI4-Lite host sequencer for the merger-tree kernel: programs the run registers,
// writes ap_start, then polls CTRL until ap_done and reports the outcome.
module sorter_ctrl_axil_master #(
    parameter int C_ADDR_WIDTH = 6,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_POLL_GAP   = 8,
    parameter int C_MAX_POLLS  = 0
) (
    input  logic                        ap_clk,
    input  logic                        areset,
    input  logic                        cmd_start,
    input  logic [63:0]                 cmd_size,
    input  logic [7:0]                  cmd_num_pass,
    input  logic [63:0]                 cmd_in_ptr,
    input  logic [63:0]                 cmd_out_ptr,
    output logic                        cmd_ready,
    output logic                        run_done,
    output logic [1:0]                  run_err,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [C_ADDR_WIDTH-1:0]     m_awaddr,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    output logic [C_DATA_WIDTH-1:0]     m_wdata,
    output logic [C_DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    input  logic [1:0]                  m_bresp,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [C_ADDR_WIDTH-1:0]     m_araddr,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [C_DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                  m_rresp
);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, POLL_AR, POLL_R, POLL_WAIT} state_t;

    state_t                    r_state;
    logic                      r_cmd_ready, r_run_done;
    logic [1:0]                r_run_err;
    logic [63:0]               r_size, r_in_ptr, r_out_ptr;
    logic [7:0]                r_num_pass;
    logic [2:0]                r_idx;
    logic                      r_issued, r_aw_done, r_w_done;
    logic                      r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [C_ADDR_WIDTH-1:0]   r_awaddr;
    logic [C_DATA_WIDTH-1:0]   r_wdata;
    logic [31:0]               r_gap_cnt, r_poll_cnt;
    logic [C_ADDR_WIDTH-1:0]   w_reg_addr;
    logic [C_DATA_WIDTH-1:0]   w_reg_data;
    logic                      w_aw_ok, w_w_ok;
    logic                      w_unused;

    // Register program: r_idx walks the write list, ap_start (CTRL=1) last
    always_comb begin
        w_reg_addr = '0;
        w_reg_data = 32'h1;
        case (r_idx)
            3'd0: begin w_reg_addr = C_ADDR_WIDTH'(8'h10); w_reg_data = r_size[31:0];         end
            3'd1: begin w_reg_addr = C_ADDR_WIDTH'(8'h14); w_reg_data = r_size[63:32];        end
            3'd2: begin w_reg_addr = C_ADDR_WIDTH'(8'h1C); w_reg_data = {24'b0, r_num_pass};  end
            3'd3: begin w_reg_addr = C_ADDR_WIDTH'(8'h24); w_reg_data = r_in_ptr[31:0];       end
            3'd4: begin w_reg_addr = C_ADDR_WIDTH'(8'h28); w_reg_data = r_in_ptr[63:32];      end
            3'd5: begin w_reg_addr = C_ADDR_WIDTH'(8'h30); w_reg_data = r_out_ptr[31:0];      end
            3'd6: begin w_reg_addr = C_ADDR_WIDTH'(8'h34); w_reg_data = r_out_ptr[63:32];     end
            default: begin w_reg_addr = '0; w_reg_data = 32'h1; end
        endcase
    end

    assign w_aw_ok  = r_aw_done || (r_awvalid && m_awready);
    assign w_w_ok   = r_w_done  || (r_wvalid  && m_wready);
    assign w_unused = ^{m_rdata[C_DATA_WIDTH-1:2], m_rdata[0]};

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_run_done  <= 1'b0;
            r_run_err   <= 2'd0;
            r_size      <= '0;
            r_in_ptr    <= '0;
            r_out_ptr   <= '0;
            r_num_pass  <= '0;
            r_idx       <= '0;
            r_issued    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_gap_cnt   <= '0;
            r_poll_cnt  <= '0;
        end else begin
            r_run_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_start && r_cmd_ready) begin
                        r_size      <= cmd_size;
                        r_num_pass  <= cmd_num_pass;
                        r_in_ptr    <= cmd_in_ptr;
                        r_out_ptr   <= cmd_out_ptr;
                        r_run_err   <= 2'd0;
                        r_idx       <= 3'd0;
                        r_issued    <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= WR_AW_W;
                    end
                end
                WR_AW_W: begin
                    if (!r_issued) begin
                        r_issued  <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_awaddr  <= w_reg_addr;
                        r_wdata   <= w_reg_data;
                    end else begin
                        if (r_awvalid && m_awready) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (r_wvalid && m_wready) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if (w_aw_ok && w_w_ok) begin
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_issued  <= 1'b0;
                            r_bready  <= 1'b1;
                            r_state   <= WR_B;
                        end
                    end
                end
                WR_B: begin
                    if (m_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_bresp != 2'b00) begin
                            r_run_err   <= 2'd1;
                            r_run_done  <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= IDLE;
                        end else if (r_idx == 3'd7) begin
                            r_poll_cnt <= '0;
                            r_state    <= POLL_AR;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= WR_AW_W;
                        end
                    end
                end
                POLL_AR: begin
                    if (!r_issued) begin
                        r_issued  <= 1'b1;
                        r_arvalid <= 1'b1;
                    end else if (m_arready) begin
                        r_issued  <= 1'b0;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (m_rvalid) begin
                        r_rready <= 1'b0;
                        if (m_rresp != 2'b00 || m_rdata[1]
                            || (C_MAX_POLLS > 0 && r_poll_cnt == 32'(C_MAX_POLLS - 1))) begin
                            r_run_err   <= (m_rresp != 2'b00) ? 2'd2 : (m_rdata[1] ? 2'd0 : 2'd3);
                            r_run_done  <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 32'd1;
                            r_gap_cnt  <= '0;
                            r_state    <= (C_POLL_GAP == 0) ? POLL_AR : POLL_WAIT;
                        end
                    end
                end
                POLL_WAIT: begin
                    if (r_gap_cnt == 32'(C_POLL_GAP - 1))
                        r_state <= POLL_AR;
                    else
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign run_done  = r_run_done;
    assign run_err   = r_run_err;
    assign m_awvalid = r_awvalid;
    assign m_awaddr  = r_awaddr;
    assign m_wvalid  = r_wvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = '1;
    assign m_bready  = r_bready;
    assign m_arvalid = r_arvalid;
    assign m_araddr  = '0;
    assign m_rready  = r_rready;

endmodule

// File: tb/tb_sorter_ctrl_axil_master.sv
// Scoreboard bench: directed runs against a configurable AXI4-Lite slave model;
// monitors check each write, poll spacing and each run completion.
module tb_sorter_ctrl_axil_master;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_start;
    logic [63:0] cmd_size, cmd_in_ptr, cmd_out_ptr;
    logic [7:0]  cmd_num_pass;
    logic        cmd_ready, run_done;
    logic [1:0]  run_err;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [5:0]  m_awaddr, m_araddr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    sorter_ctrl_axil_master #(
        .C_ADDR_WIDTH(6), .C_DATA_WIDTH(32), .C_POLL_GAP(8), .C_MAX_POLLS(16)
    ) dut (
        .ap_clk(clk), .areset(areset),
        .cmd_start(cmd_start), .cmd_size(cmd_size), .cmd_num_pass(cmd_num_pass),
        .cmd_in_ptr(cmd_in_ptr), .cmd_out_ptr(cmd_out_ptr),
        .cmd_ready(cmd_ready), .run_done(run_done), .run_err(run_err),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; logic [31:0] data; int aw_cyc; } wr_t;
    typedef struct { logic [1:0] err; int reads; int writes; } done_t;
    wr_t   exp_wq[$];
    done_t exp_dq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model configuration and bookkeeping
    int         cfg_aw_delay  = 0;
    logic [7:0] cfg_berr_addr = 8'hFF;
    int         cfg_done_read = 0;
    int         rd_total = 0, b_total = 0;
    int         rd_base  = 0, b_base  = 0;
    int         aw_wait;
    logic       s_have_aw, s_have_w;
    logic [5:0] s_awaddr_q;
    logic       s_aw_ok, s_w_ok;
    logic [5:0] s_addr_eff;

    assign m_awready  = m_awvalid && (aw_wait >= cfg_aw_delay);
    assign m_wready   = 1'b1;
    assign m_arready  = 1'b1;
    assign s_aw_ok    = s_have_aw || (m_awvalid && m_awready);
    assign s_w_ok     = s_have_w  || (m_wvalid && m_wready);
    assign s_addr_eff = s_have_aw ? s_awaddr_q : m_awaddr;

    always @(posedge clk) begin
        if (areset) begin
            aw_wait    <= 0;
            s_have_aw  <= 1'b0;
            s_have_w   <= 1'b0;
            s_awaddr_q <= '0;
            m_bvalid   <= 1'b0;
            m_bresp    <= 2'b00;
            m_rvalid   <= 1'b0;
            m_rdata    <= '0;
            m_rresp    <= 2'b00;
        end else begin
            if (m_awvalid && !m_awready) aw_wait <= aw_wait + 1;
            if (m_awvalid && m_awready) aw_wait <= 0;
            if (s_aw_ok && s_w_ok && !m_bvalid) begin
                m_bvalid  <= 1'b1;
                m_bresp   <= ({2'b00, s_addr_eff} == cfg_berr_addr) ? 2'b10 : 2'b00;
                s_have_aw <= 1'b0;
                s_have_w  <= 1'b0;
            end else begin
                if (m_awvalid && m_awready) begin
                    s_have_aw  <= 1'b1;
                    s_awaddr_q <= m_awaddr;
                end
                if (m_wvalid && m_wready) s_have_w <= 1'b1;
            end
            if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0;
                b_total  <= b_total + 1;
            end
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rresp  <= 2'b00;
                m_rdata  <= ((rd_total - rd_base + 1) == cfg_done_read) ? 32'h2 : 32'h0;
                rd_total <= rd_total + 1;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    // Write monitor: one comparison set per completed AW+W pair
    logic        wm_have_aw, wm_have_w;
    int          wm_aw_cyc, wm_w_cyc, wm_cap_aw_cyc, wm_cap_w_cyc;
    logic [5:0]  wm_addr;
    logic [31:0] wm_data;
    logic [3:0]  wm_strb;
    wr_t         wm_e;

    always @(negedge clk) begin
        if (areset) begin
            wm_have_aw = 1'b0; wm_have_w = 1'b0; wm_aw_cyc = 0; wm_w_cyc = 0;
        end else begin
            if (m_awvalid) wm_aw_cyc++;
            if (m_wvalid)  wm_w_cyc++;
            if (m_awvalid && m_awready) begin
                wm_have_aw = 1'b1; wm_addr = m_awaddr;
                wm_cap_aw_cyc = wm_aw_cyc; wm_aw_cyc = 0;
            end
            if (m_wvalid && m_wready) begin
                wm_have_w = 1'b1; wm_data = m_wdata; wm_strb = m_wstrb;
                wm_cap_w_cyc = wm_w_cyc; wm_w_cyc = 0;
            end
            if (wm_have_aw && wm_have_w) begin
                wm_have_aw = 1'b0; wm_have_w = 1'b0;
                check("write_expected", exp_wq.size() > 0, 1);
                if (exp_wq.size() > 0) begin
                    wm_e = exp_wq.pop_front();
                    $display("write addr=0x%02h data=0x%08h awcyc=%0d", wm_addr, wm_data, wm_cap_aw_cyc);
                    check("awaddr", wm_addr, wm_e.addr);
                    check("wdata", wm_data, wm_e.data);
                    check("wstrb", wm_strb, 4'hF);
                    check("awvalid_cycles", wm_cap_aw_cyc, wm_e.aw_cyc);
                    check("wvalid_cycles", wm_cap_w_cyc, 1);
                end
            end
        end
    end

    // Completion and poll-spacing monitor
    logic  dm_have_r, dm_prev_ar, dm_prev_done;
    int    dm_last_r, done_cnt = 0;
    done_t dm_e;

    always @(negedge clk) begin
        if (areset) begin
            dm_have_r = 1'b0; dm_prev_ar = 1'b0; dm_prev_done = 1'b0;
        end else begin
            if (m_arvalid && m_arready) check("araddr", m_araddr, 6'h00);
            if (m_arvalid && !dm_prev_ar && dm_have_r)
                check("poll_gap_ge8", (cyc - dm_last_r - 1) >= 8, 1);
            if (m_rvalid && m_rready) begin
                dm_have_r = 1'b1; dm_last_r = cyc;
            end
            dm_prev_ar = m_arvalid;
            if (run_done) begin
                done_cnt++;
                dm_have_r = 1'b0;
                $display("run_done err=%0d reads=%0d bresps=%0d", run_err, rd_total - rd_base, b_total - b_base);
                check("run_done_one_cycle", dm_prev_done, 0);
                check("done_expected", exp_dq.size() > 0, 1);
                if (exp_dq.size() > 0) begin
                    dm_e = exp_dq.pop_front();
                    check("run_err", run_err, dm_e.err);
                    check("read_count", rd_total - rd_base, dm_e.reads);
                    check("b_handshakes", b_total - b_base, dm_e.writes);
                end
            end
            dm_prev_done = run_done;
        end
    end

    task automatic run_cmd(input logic [63:0] sz, input logic [7:0] np, input logic [63:0] ip,
                           input logic [63:0] op, input int aw_cyc, input int n_wr,
                           input logic [1:0] err, input int reads);
        logic [7:0]  a[8];
        logic [31:0] d[8];
        wr_t   w;
        done_t dn;
        a[0] = 8'h10; d[0] = sz[31:0];
        a[1] = 8'h14; d[1] = sz[63:32];
        a[2] = 8'h1C; d[2] = {24'b0, np};
        a[3] = 8'h24; d[3] = ip[31:0];
        a[4] = 8'h28; d[4] = ip[63:32];
        a[5] = 8'h30; d[5] = op[31:0];
        a[6] = 8'h34; d[6] = op[63:32];
        a[7] = 8'h00; d[7] = 32'h1;
        for (int i = 0; i < n_wr; i++) begin
            w.addr = a[i]; w.data = d[i]; w.aw_cyc = aw_cyc;
            exp_wq.push_back(w);
        end
        dn.err = err; dn.reads = reads; dn.writes = n_wr;
        exp_dq.push_back(dn);
        check("cmd_ready_before_start", cmd_ready, 1);
        cmd_size = sz; cmd_num_pass = np; cmd_in_ptr = ip; cmd_out_ptr = op;
        rd_base = rd_total; b_base = b_total;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("run_done_within_bound", done_cnt >= target, 1);
        @(negedge clk);
        check("writes_consumed", exp_wq.size(), 0);
    endtask

    int saved;

    initial begin
        areset = 1'b1; cmd_start = 1'b0;
        cmd_size = '0; cmd_num_pass = '0; cmd_in_ptr = '0; cmd_out_ptr = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {cmd_ready, run_done, run_err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        areset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        // 1: nominal run, zero-wait slave, done on 2nd read
        cfg_aw_delay = 0; cfg_berr_addr = 8'hFF; cfg_done_read = 2;
        run_cmd(64'h1000, 8'd3, 64'h1_0000_0000, 64'h2_0000_0000, 1, 8, 2'd0, 2);
        wait_done(done_cnt + 1);

        // 2: AW stalled 5 cycles on every write
        cfg_aw_delay = 5; cfg_done_read = 1;
        run_cmd(64'hDEAD_BEEF_1234_5678, 8'hA5, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 6, 8, 2'd0, 1);
        wait_done(done_cnt + 1);

        // 3: SLVERR on the num_pass write aborts the program
        cfg_aw_delay = 0; cfg_berr_addr = 8'h1C; cfg_done_read = 1;
        run_cmd(64'h40, 8'd7, 64'h100, 64'h200, 1, 3, 2'd1, 0);
        wait_done(done_cnt + 1);
        check("cmd_ready_after_berr", cmd_ready, 1);
        repeat (20) @(negedge clk);
        check("no_write_after_berr", exp_wq.size(), 0);
        cfg_berr_addr = 8'hFF;

        // 4: done on 4th read; a cmd_start mid-run must be ignored
        cfg_done_read = 4;
        run_cmd(64'h8000, 8'd5, 64'h3000, 64'h4000, 1, 8, 2'd0, 4);
        repeat (3) @(negedge clk);
        cmd_size = 64'hFFFF; cmd_num_pass = 8'hEE; cmd_in_ptr = 64'hBAD; cmd_out_ptr = 64'hBAD;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done(done_cnt + 1);

        // 5: slave never done -> timeout after 16 reads
        cfg_done_read = 0;
        run_cmd(64'h10, 8'd1, 64'h500, 64'h600, 1, 8, 2'd3, 16);
        wait_done(done_cnt + 1);

        // 6: reset while awvalid is held, then a normal run
        cfg_aw_delay = 5; cfg_done_read = 1;
        run_cmd(64'h20, 8'd2, 64'h700, 64'h800, 6, 8, 2'd0, 1);
        begin
            int k = 0;
            while (!m_awvalid && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("awvalid_seen_before_reset", m_awvalid, 1);
        areset = 1'b1;
        exp_wq.delete();
        exp_dq.delete();
        saved = done_cnt;
        @(negedge clk);
        check("reset_drops_valids", {m_awvalid, m_wvalid}, 2'b00);
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_midrun_reset", cmd_ready, 1);
        repeat (10) @(negedge clk);
        check("no_run_done_on_reset", done_cnt, saved);
        cfg_aw_delay = 0; cfg_done_read = 2;
        run_cmd(64'h1000, 8'd3, 64'h1_0000_0000, 64'h2_0000_0000, 1, 8, 2'd0, 2);
        wait_done(done_cnt + 1);

        repeat (5) @(negedge clk);
        check("queues_empty", exp_wq.size() + exp_dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
